wash_seq_core: RTL and testbench
================================

// Module: wash_seq_core
// PURPOSE
//  Parametrised successor sequencer core for the washing register machine.
//  Fetches 32-bit instrs {arg[31:16], reg_id[15:8], opcode[7:0]} from an external ROM addressed by pc.
//  Drives CTRL_NUM actuator channels for timed durations, with pause/abort, saturating register arithmetic and a sticky error flag.
//  Sits between the program ROM and the actuator drivers; timing is paced by an external tick.
// PARAMETERS
//  ADDR_WIDTH   8     pc / program address width
//  REG_NUM      4     general registers, 16 bit each; reg_id >= REG_NUM is illegal
//  CTRL_NUM     4     actuator channels, 1..15
//  BOOT_ADDR    2     pc loaded on start
//  STACK_DEPTH  4     return-stack entries (WRM_CALL_STACK_EN only)
// PORTS
//  clk      in   1           clock, rising edge
//  rst_n    in   1           reset, asynchronous, active-low
//  start    in   1           boot request; honoured in IDLE only
//  pause    in   1           freeze execution; ctrl forced low
//  abort    in   1           return to IDLE; priority over everything except reset
//  tick     in   1           timebase strobe; one cycle = one time unit
//  instr    in   32          instr at pc, combinational, same cycle
//  pc       out  ADDR_WIDTH  program counter (registered)
//  ctrl     out  CTRL_NUM    actuator enables, one-hot or zero
//  busy     out  1           state != IDLE
//  err      out  1           sticky illegal-op / stack error
// BEHAVIOUR
//  Reset: pc=0, state=IDLE, regs=0, timer=0, ctrl=0, busy=0, err=0; stack empty.
//  FSM IDLE/RUN/TIMED. IDLE: start -> pc<=BOOT_ADDR, err<=0, RUN; else hold.
//  RUN executes instr[pc] in one cycle; pause high -> hold all state, no side effects.
//  Opcodes (RUN):
//   0x00 HALT -> IDLE, pc holds.
//   0x10 WAIT, 0x11+c ACT ch c (c<CTRL_NUM): timer<=arg, -> TIMED; arg==0 -> pc+1, stay RUN.
//   0x21 SET r<=arg; 0x22 DEC r, saturates at 0; 0x23 INC r, wraps 0xFFFF->0. pc+1.
//   0x30 J pc<=arg[ADDR_WIDTH-1:0]; 0x31 JZ / 0x32 JNZ on reg[reg_id]==0 / !=0; not taken -> pc+1.
//  TIMED: ctrl[c]=~pause (WAIT: ctrl=0); on tick & ~pause timer<=timer-1.
//   timer==1 & tick & ~pause -> pc<=pc+1, RUN; channel high for exactly arg ticks.
//  Illegal opcode, reg_id>=REG_NUM, ACT c>=CTRL_NUM: err<=1, treated as NOP, pc+1.
//  pc arithmetic modulo 2^ADDR_WIDTH (wraps); jump target truncated to ADDR_WIDTH.
//  abort (any state): next cycle IDLE, pc<=0, timer<=0, ctrl=0; regs and err kept.
//  start while busy ignored; start+abort same cycle -> abort wins.
//  ctrl is combinational from state/timer/pause; busy registered-state decode.
// CONFIGURATION
//  WRM_CALL_STACK_EN defined: 0x40 CALL pushes pc+1, pc<=arg; 0x41 RET pops into pc.
//   CALL when full / RET when empty: err<=1, pc+1, stack unchanged. abort and IDLE->RUN clear the stack.
//  Undefined: no stack logic; 0x40/0x41 are illegal (err<=1, NOP).
// TESTING
//  Reset, start; ROM[2]=SET r1,3; ROM[3]=HALT -> pc 2,3 then IDLE, reg1=3, busy 1->0.
//  ACT ch1 arg=5, tick every 4 cycles -> ctrl=4'b0010 for exactly 5 ticks, then pc+1.
//  Pause for 7 cycles mid ACT -> ctrl=0, timer frozen; total high ticks still 5.
//  DEC on reg=0 -> stays 0; JZ taken to 0x20; JNZ not taken -> pc+1; INC 0xFFFF -> 0.
//  Opcode 0x7F, then abort mid-TIMED -> err=1 stays set; next cycle pc=0, IDLE, ctrl=0.
//  With WRM_CALL_STACK_EN, STACK_DEPTH=2: CALL x3 -> 3rd sets err; RET,RET return correctly.

Source files
------------

// File: rtl/wash_seq_core.sv
// Successor sequencer for the washing register machine: fetches {arg, reg_id, opcode} at pc and drives timed actuator channels.
// Optional return stack (CALL/RET) is built only when WRM_CALL_STACK_EN is defined.
module wash_seq_core #(
  parameter int ADDR_WIDTH  = 8,
  parameter int REG_NUM     = 4,
  parameter int CTRL_NUM    = 4,
  parameter int BOOT_ADDR   = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  abort,
  input  logic                  tick,
  input  logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [CTRL_NUM-1:0]   ctrl,
  output logic                  busy,
  output logic                  err
);

  localparam int RIW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  typedef enum logic [1:0] {IDLE, RUN, TIMED} state_t;

  state_t      state;
  logic [15:0] regs [REG_NUM];
  logic [15:0] timer;
  logic [3:0]  act_ch;
  logic        act_on;

  logic [15:0]           arg;
  logic [7:0]            reg_id;
  logic [7:0]            opcode;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] target;
  logic [RIW-1:0]        ridx;
  logic [15:0]           rval;
  logic                  reg_ok;
  logic                  is_act;
  logic [3:0]            act_c;
  logic                  act_legal;

  assign arg       = instr[31:16];
  assign reg_id    = instr[15:8];
  assign opcode    = instr[7:0];
  assign pc_inc    = pc + 1'b1;
  assign target    = arg[ADDR_WIDTH-1:0];
  assign ridx      = reg_id[RIW-1:0];
  assign rval      = regs[ridx];
  assign reg_ok    = (int'(reg_id) < REG_NUM);
  assign is_act    = (opcode[7:4] == 4'h1) && (opcode[3:0] != 4'h0);
  assign act_c     = opcode[3:0] - 4'd1;
  assign act_legal = (int'(act_c) < CTRL_NUM);

  // A plain WAIT keeps act_on low so no channel is driven while counting.
  assign ctrl = (state == TIMED && act_on && !pause) ? (CTRL_NUM'(1) << act_ch) : '0;
  assign busy = (state != IDLE);

`ifdef WRM_CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
  logic [SPW-1:0]        sp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= '0;
      timer  <= '0;
      act_ch <= '0;
      act_on <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
`ifdef WRM_CALL_STACK_EN
      sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
`endif
    end else if (abort) begin
      state <= IDLE;
      pc    <= '0;
      timer <= '0;
`ifdef WRM_CALL_STACK_EN
      sp <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= ADDR_WIDTH'(BOOT_ADDR);
            err   <= 1'b0;
`ifdef WRM_CALL_STACK_EN
            sp <= '0;
`endif
          end
        end
        TIMED: begin
          if (tick && !pause) begin
            timer <= timer - 1'b1;
            if (timer == 16'd1) begin
              pc    <= pc_inc;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!pause) begin
            // Every opcode advances by default; branches and timed ops override below.
            pc <= pc_inc;
            case (opcode)
              8'h00: begin
                pc    <= pc;
                state <= IDLE;
              end
              8'h21: if (reg_ok) regs[ridx] <= arg; else err <= 1'b1;
              8'h22: begin
                if (!reg_ok) err <= 1'b1;
                else if (rval != 16'd0) regs[ridx] <= rval - 16'd1;
              end
              8'h23: if (reg_ok) regs[ridx] <= rval + 16'd1; else err <= 1'b1;
              8'h30: pc <= target;
              8'h31: begin
                if (!reg_ok) err <= 1'b1;
                else if (rval == 16'd0) pc <= target;
              end
              8'h32: begin
                if (!reg_ok) err <= 1'b1;
                else if (rval != 16'd0) pc <= target;
              end
`ifdef WRM_CALL_STACK_EN
              8'h40: begin
                if (sp == SPW'(STACK_DEPTH)) err <= 1'b1;
                else begin
                  stack[SIW'(sp)] <= pc_inc;
                  sp              <= sp + 1'b1;
                  pc              <= target;
                end
              end
              8'h41: begin
                if (sp == '0) err <= 1'b1;
                else begin
                  pc <= stack[SIW'(sp - 1'b1)];
                  sp <= sp - 1'b1;
                end
              end
`endif
              default: begin
                if (opcode == 8'h10 || (is_act && act_legal)) begin
                  act_on <= is_act;
                  act_ch <= act_c;
                  if (arg != 16'd0) begin
                    timer <= arg;
                    state <= TIMED;
                    pc    <= pc;
                  end
                end else begin
                  err <= 1'b1;
                end
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wash_seq_core.sv
// Bench for wash_seq_core: directed programs with literal expectations plus randomized ROMs checked each cycle against a program-level model.
module tb_wash_seq_core;

  localparam int AW   = 8;
  localparam int RN   = 4;
  localparam int CN   = 4;
  localparam int BOOT = 2;
  localparam int SD   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic          tick = 1'b0;
  logic [31:0]   instr;
  logic [AW-1:0] pc;
  logic [CN-1:0] ctrl;
  logic          busy;
  logic          err;

  logic [31:0] rom [256];
  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Model: machine is either stopped, executing, or counting down a timed op on channel m_chan (-1 = WAIT).
  int m_pc = 0;
  int m_timer = 0;
  int m_chan = -1;
  bit m_busy = 1'b0;
  bit m_timed = 1'b0;
  bit m_err = 1'b0;
  int m_regs [RN];
  int m_stack [$];

  always #5 clk = ~clk;

  assign instr = rom[pc];

  wash_seq_core #(
    .ADDR_WIDTH(AW), .REG_NUM(RN), .CTRL_NUM(CN), .BOOT_ADDR(BOOT), .STACK_DEPTH(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort), .tick(tick),
    .instr(instr), .pc(pc), .ctrl(ctrl), .busy(busy), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    logic [31:0] ins;
    int op, rid, arg, nxt;
    bit uses_reg;
    if (!rst_n) begin
      m_pc = 0; m_timer = 0; m_chan = -1; m_busy = 0; m_timed = 0; m_err = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
      m_stack.delete();
      return;
    end
    if (abort) begin
      m_busy = 0; m_timed = 0; m_pc = 0; m_timer = 0;
      m_stack.delete();
      return;
    end
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_pc = BOOT; m_err = 0;
        m_stack.delete();
      end
      return;
    end
    if (pause) return;
    if (m_timed) begin
      if (tick) begin
        m_timer = m_timer - 1;
        if (m_timer == 0) begin
          m_timed = 0;
          m_pc = (m_pc + 1) % 256;
        end
      end
      return;
    end
    ins = rom[m_pc];
    op  = int'(ins[7:0]);
    rid = int'(ins[15:8]);
    arg = int'(ins[31:16]);
    nxt = (m_pc + 1) % 256;
    uses_reg = (op == 'h21 || op == 'h22 || op == 'h23 || op == 'h31 || op == 'h32);
    if (uses_reg && rid >= RN) begin
      m_err = 1; m_pc = nxt;
      return;
    end
    if (op == 0) begin
      m_busy = 0;
    end else if (op == 'h10 || (op >= 'h11 && op < 'h11 + CN)) begin
      m_chan = (op == 'h10) ? -1 : op - 'h11;
      if (arg == 0) m_pc = nxt;
      else begin
        m_timed = 1; m_timer = arg;
      end
    end else if (op == 'h21) begin
      m_regs[rid] = arg; m_pc = nxt;
    end else if (op == 'h22) begin
      if (m_regs[rid] > 0) m_regs[rid] = m_regs[rid] - 1;
      m_pc = nxt;
    end else if (op == 'h23) begin
      m_regs[rid] = (m_regs[rid] + 1) % 65536; m_pc = nxt;
    end else if (op == 'h30) begin
      m_pc = arg % 256;
    end else if (op == 'h31) begin
      m_pc = (m_regs[rid] == 0) ? arg % 256 : nxt;
    end else if (op == 'h32) begin
      m_pc = (m_regs[rid] != 0) ? arg % 256 : nxt;
`ifdef WRM_CALL_STACK_EN
    end else if (op == 'h40) begin
      if (m_stack.size() == SD) begin
        m_err = 1; m_pc = nxt;
      end else begin
        m_stack.push_back(nxt); m_pc = arg % 256;
      end
    end else if (op == 'h41) begin
      if (m_stack.size() == 0) begin
        m_err = 1; m_pc = nxt;
      end else m_pc = m_stack.pop_back();
`endif
    end else begin
      m_err = 1; m_pc = nxt;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    int exp_ctrl;
    @(negedge clk);
    if (chk_en) begin
      exp_ctrl = 0;
      if (m_busy && m_timed && m_chan >= 0 && !pause) exp_ctrl = 1 << m_chan;
      check("cyc_pc", 32'(pc), 32'(m_pc));
      check("cyc_ctrl", 32'(ctrl), 32'(exp_ctrl));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_err", 32'(err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  task automatic boot();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_act(input bit with_pause);
    int high = 0;
    clear_rom();
    rom[2] = 32'h0005_0012;
    rom[3] = 32'h0000_0000;
    boot();
    for (int i = 0; i < 200 && busy; i++) begin
      tick  = (i % 4 == 3);
      pause = with_pause && i >= 8 && i < 15;
      #1;
      if (ctrl == 4'b0010 && tick) high++;
      if (i == 5) check("act_ctrl_on", 32'(ctrl), 32'h2);
      if (with_pause && i == 10) check("act_ctrl_paused", 32'(ctrl), 32'h0);
      step();
    end
    tick = 1'b0;
    pause = 1'b0;
    check(with_pause ? "act_pause_ticks" : "act_ticks", 32'(high), 32'd5);
    check("act_done", 32'(busy), 32'd0);
    check("act_pc", 32'(pc), 32'd3);
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [7:0] op, r;
    logic [15:0] a;
    k = $urandom_range(0, 15);
    r = 8'($urandom_range(0, 4));
    a = 16'($urandom_range(0, 4));
    case (k)
      0:       op = 8'h00;
      1:       op = 8'h10;
      2, 3:    op = 8'(8'h11 + $urandom_range(0, 4));
      4, 5: begin
        op = 8'h21;
        case ($urandom_range(0, 3))
          0:       a = 16'h0000;
          1:       a = 16'hFFFF;
          2:       a = 16'h0001;
          default: a = 16'($urandom_range(0, 65535));
        endcase
      end
      6:       op = 8'h22;
      7:       op = 8'h23;
      8:  begin op = 8'h30; a = 16'($urandom_range(0, 65535)); end
      9:  begin op = 8'h31; a = 16'($urandom_range(0, 65535)); end
      10: begin op = 8'h32; a = 16'($urandom_range(0, 65535)); end
      11: begin op = 8'h40; a = 16'($urandom_range(0, 65535)); end
      12:      op = 8'h41;
      13:      op = 8'h7F;
      default: op = 8'h23;
    endcase
    return {a, r, op};
  endfunction

  initial begin
    clear_rom();
    repeat (3) step();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // SET r1,3 then HALT
    rom[2] = 32'h0003_0121;
    rom[3] = 32'h0000_0000;
    boot();
    check("a_pc_boot", 32'(pc), 32'd2);
    check("a_busy", 32'(busy), 32'd1);
    step();
    check("a_pc_set", 32'(pc), 32'd3);
    step();
    check("a_idle", 32'(busy), 32'd0);
    check("a_pc_halt", 32'(pc), 32'd3);
    check("a_model_r1", 32'(m_regs[1]), 32'd3);

    run_act(1'b0);
    run_act(1'b1);

    // DEC at 0, JZ taken, JNZ not taken, INC wrap then JZ taken
    clear_rom();
    rom[2]  = 32'h0000_0021;
    rom[3]  = 32'h0000_0022;
    rom[4]  = 32'h0020_0031;
    rom[32] = 32'h0050_0032;
    rom[33] = 32'hFFFF_0221;
    rom[34] = 32'h0000_0223;
    rom[35] = 32'h0030_0231;
    rom[48] = 32'h0000_0000;
    boot();
    repeat (3) step();
    check("b_jz_taken", 32'(pc), 32'h20);
    step();
    check("b_jnz_not_taken", 32'(pc), 32'h21);
    repeat (3) step();
    check("b_inc_wrap_jz", 32'(pc), 32'h30);
    step();
    check("b_idle", 32'(busy), 32'd0);
    check("b_model_r0", 32'(m_regs[0]), 32'd0);
    check("b_model_r2", 32'(m_regs[2]), 32'd0);

    // illegal opcode, then abort mid-TIMED
    clear_rom();
    rom[2] = 32'h0000_007F;
    rom[3] = 32'h000A_0013;
    rom[4] = 32'h0000_0000;
    boot();
    step();
    check("c_err_set", 32'(err), 32'd1);
    check("c_pc_nop", 32'(pc), 32'd3);
    step();
    step();
    check("c_ctrl_ch2", 32'(ctrl), 32'h4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("c_abort_pc", 32'(pc), 32'd0);
    check("c_abort_busy", 32'(busy), 32'd0);
    check("c_abort_ctrl", 32'(ctrl), 32'd0);
    check("c_err_kept", 32'(err), 32'd1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("c_abort_beats_start", 32'(busy), 32'd0);

    // CALL/RET sequence; without the stack these are illegal NOPs
    clear_rom();
    rom[2]  = 32'h0010_0040;
    rom[16] = 32'h0020_0040;
    rom[17] = 32'h0000_0041;
    rom[32] = 32'h0030_0040;
    rom[33] = 32'h0000_0041;
    rom[3]  = 32'h0000_0000;
    boot();
    check("d_err_cleared", 32'(err), 32'd0);
`ifdef WRM_CALL_STACK_EN
    step();
    check("d_call1", 32'(pc), 32'h10);
    step();
    check("d_call2", 32'(pc), 32'h20);
    step();
    check("d_call_full_pc", 32'(pc), 32'h21);
    check("d_call_full_err", 32'(err), 32'd1);
    step();
    check("d_ret1", 32'(pc), 32'h11);
    step();
    check("d_ret2", 32'(pc), 32'h03);
`else
    step();
    check("d_call_illegal_err", 32'(err), 32'd1);
    check("d_call_illegal_pc", 32'(pc), 32'd3);
`endif
    step();
    check("d_idle", 32'(busy), 32'd0);

    // randomized programs and control inputs
    for (int p = 0; p < 4; p++) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = rand_instr();
      for (int c = 0; c < 1500; c++) begin
        start = ($urandom_range(0, 7) == 0);
        abort = ($urandom_range(0, 99) == 0);
        pause = ($urandom_range(0, 9) == 0);
        tick  = ($urandom_range(0, 2) == 0);
        step();
      end
    end
    start = 1'b0;
    abort = 1'b0;
    pause = 1'b0;
    tick  = 1'b0;
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
